// File: rtl/mem_seq_writer_if.sv
// Bus bundle for mem_seq_writer: start/valid/ready byte stream in,
// fill-progress status out, and an independent read port.
interface mem_seq_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Writer side
    modport slave (
        input  start, in_valid, in_data, rd_addr,
        output in_ready, wr_addr, count, full, done, rd_data
    );

    // Source / reader side
    modport master (
        output start, in_valid, in_data, rd_addr,
        input  in_ready, wr_addr, count, full, done, rd_data
    );
endinterface

// File: rtl/mem_seq_writer.sv
// Sequential writer: after a start pulse, fills DEPTH register words from a
// valid/ready byte stream at auto-incrementing addresses, then reports
// full/done. A combinational read port exposes any word at any time.
module mem_seq_writer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_seq_writer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   COUNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              accept;
    logic [DATA_W-1:0] mem_words [DEPTH];

    // in_ready is a pure state decode, so accept never loops back into in_ready.
    assign accept = (state_q == S_FILL) && bus.in_valid;

    // Next-state and pointer/counter updates for the fill sequencer.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_FILL;
                    wr_addr_d = '0;
                    count_d   = '0;
                end
            end
            S_FILL: begin
                // start is deliberately ignored here, even on the final beat.
                if (accept) begin
                    if (count_q == COUNT_LAST) begin
                        state_d   = S_FULL;
                        wr_addr_d = '0;
                        count_d   = count_q + COUNT_ONE;
                        done_d    = 1'b1;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                        count_d   = count_q + COUNT_ONE;
                    end
                end
            end
            S_FULL: begin
                // Old contents stay in place until the new pass overwrites them.
                if (bus.start) begin
                    state_d   = S_FILL;
                    wr_addr_d = '0;
                    count_d   = '0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                wr_addr_d = '0;
                count_d   = '0;
            end
        endcase
    end

    // Sequencer state registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    // One register word per location; async clear is why this is not block RAM.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_W-1:0] word_q, word_d;

            // Load the word only when the accepted beat targets this address.
            always_comb begin
                word_d = word_q;
                if (accept && (wr_addr_q == ADDR_W'(gi))) begin
                    word_d = bus.in_data;
                end
            end

            // Word storage, cleared asynchronously with the sequencer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign mem_words[gi] = word_q;
        end
    endgenerate

    assign bus.in_ready = (state_q == S_FILL);
    assign bus.full     = (state_q == S_FULL);
    assign bus.done     = done_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.count    = count_q;
    // DEPTH equals 2**ADDR_W, so every rd_addr value is a valid index.
    assign bus.rd_data  = mem_words[bus.rd_addr];

endmodule

// File: tb/tb_mem_seq_writer.sv
// Directed bench for mem_seq_writer: reset state, back-to-back and stalled
// fills, FULL-state rejection, restart, async mid-pass reset, read latency.
module tb_mem_seq_writer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    mem_seq_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_seq_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read all words; expected word k = base + k*stride. Takes 8 ns.
    task automatic check_mem(input string tag, input logic [7:0] base, input logic [7:0] stride);
        for (int k = 0; k < DEPTH; k++) begin
            bus.rd_addr = ADDR_W'(k);
            #1;
            chk($sformatf("%s_mem%0d", tag, k), 32'(bus.rd_data), 32'(8'(base + 8'(k) * stride)));
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_addr  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_full",     32'(bus.full),     0);
        chk("rst_done",     32'(bus.done),     0);
        chk("rst_count",    32'(bus.count),    0);
        chk("rst_wr_addr",  32'(bus.wr_addr),  0);
        check_mem("rst", 8'h00, 8'h00);

        // Back-to-back fill 0x11..0x88
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(17 * (k + 1));
            chk($sformatf("b2b_wr_addr%0d", k),  32'(bus.wr_addr),  32'(k));
            chk($sformatf("b2b_count%0d", k),    32'(bus.count),    32'(k));
            chk($sformatf("b2b_in_ready%0d", k), 32'(bus.in_ready), 1);
            chk($sformatf("b2b_done%0d", k),     32'(bus.done),     0);
            step();
        end
        bus.in_valid = 1'b0;
        chk("b2b_done_pulse", 32'(bus.done),     1);
        chk("b2b_full",       32'(bus.full),     1);
        chk("b2b_count_end",  32'(bus.count),    8);
        chk("b2b_wr_wrap",    32'(bus.wr_addr),  0);
        chk("b2b_ready_off",  32'(bus.in_ready), 0);
        step();
        chk("b2b_done_drop",  32'(bus.done), 0);
        chk("b2b_full_hold",  32'(bus.full), 1);
        check_mem("b2b", 8'h11, 8'h11);

        // FULL rejects beats
        step();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("full_ready%0d", k), 32'(bus.in_ready), 0);
            step();
            chk($sformatf("full_count%0d", k), 32'(bus.count), 8);
        end
        bus.in_valid = 1'b0;
        check_mem("full_keep", 8'h11, 8'h11);

        // start held two cycles, then 0xA0..0xA7 with start on the last beat
        step();
        bus.start = 1'b1;
        step();
        chk("rs_full_drop", 32'(bus.full),     0);
        chk("rs_ready",     32'(bus.in_ready), 1);
        chk("rs_count0",    32'(bus.count),    0);
        chk("rs_wr_addr0",  32'(bus.wr_addr),  0);
        step();
        chk("rs_hold_ready", 32'(bus.in_ready), 1);
        chk("rs_hold_full",  32'(bus.full),     0);
        bus.start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'hA0 + k);
            bus.start    = (k == DEPTH - 1);
            step();
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk("rs_full", 32'(bus.full),  1);
        chk("rs_done", 32'(bus.done),  1);
        chk("rs_count",32'(bus.count), 8);
        check_mem("rs", 8'hA0, 8'h01);

        // Fill with in_valid low on alternate cycles
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.in_data  = 8'(17 * (k / 2 + 1));
            chk($sformatf("stall_count%0d", k), 32'(bus.count), 32'((k + 1) / 2));
            chk($sformatf("stall_done%0d", k),  32'(bus.done),  0);
            step();
        end
        bus.in_valid = 1'b0;
        chk("stall_done_pulse", 32'(bus.done),  1);
        chk("stall_count_end",  32'(bus.count), 8);
        chk("stall_full",       32'(bus.full),  1);
        step();
        chk("stall_done_drop",  32'(bus.done),  0);
        check_mem("stall", 8'h11, 8'h11);

        // Async reset after three beats
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(k + 1);
            step();
        end
        bus.in_valid = 1'b0;
        bus.rd_addr  = 3'd1;
        #1;
        chk("pre_rst_rd1",    32'(bus.rd_data), 32'h02);
        chk("pre_rst_count",  32'(bus.count),   3);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count",    32'(bus.count),    0);
        chk("arst_wr_addr",  32'(bus.wr_addr),  0);
        chk("arst_in_ready", 32'(bus.in_ready), 0);
        chk("arst_full",     32'(bus.full),     0);
        chk("arst_done",     32'(bus.done),     0);
        chk("arst_rd1",      32'(bus.rd_data),  0);
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(bus.in_ready), 0);
        // in_valid in IDLE is ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        step();
        bus.in_valid = 1'b0;
        chk("idle_count",   32'(bus.count),   0);
        chk("idle_wr_addr", 32'(bus.wr_addr), 0);
        check_mem("post_rst", 8'h00, 8'h00);

        // Read-during-write latency at address 2
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("lat_wr_addr0", 32'(bus.wr_addr),  0);
        chk("lat_ready",    32'(bus.in_ready), 1);
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(16 * (k + 1));
            step();
        end
        bus.rd_addr  = 3'd2;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        #1;
        chk("lat_wr_addr2", 32'(bus.wr_addr), 2);
        chk("lat_same_cyc", 32'(bus.rd_data), 32'h00);
        step();
        bus.in_valid = 1'b0;
        chk("lat_next_cyc", 32'(bus.rd_data), 32'h5A);
        chk("lat_count",    32'(bus.count),   3);
        bus.rd_addr = 3'd1;
        #1;
        chk("lat_rd1", 32'(bus.rd_data), 32'h20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
